board_stager: RTL and testbench

//  Upstream feeder for the vchess evaluator. Assembles a full board from rank-wide writes issued by

---
 rtl/vchess_pkg.sv | 25 ++
 rtl/board_stager.sv | 148 ++++++++++++++
 tb/tb_board_stager.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vchess_pkg.sv
// Shared vchess definitions: piece encoding and the board stager state type.
package vchess_pkg;

  // Bits used to encode one square.
  localparam int PIECE_BITS = 4;

  // Piece codes; bit 3 marks a black piece.
  localparam logic [PIECE_BITS-1:0] EMPTY_POSN   = 4'h0;
  localparam logic [PIECE_BITS-1:0] WHITE_PAWN   = 4'h1;
  localparam logic [PIECE_BITS-1:0] WHITE_KNIGHT = 4'h2;
  localparam logic [PIECE_BITS-1:0] WHITE_BISHOP = 4'h3;
  localparam logic [PIECE_BITS-1:0] WHITE_ROOK   = 4'h4;
  localparam logic [PIECE_BITS-1:0] WHITE_QUEEN  = 4'h5;
  localparam logic [PIECE_BITS-1:0] WHITE_KING   = 4'h6;
  localparam logic [PIECE_BITS-1:0] BLACK_PAWN   = 4'h9;
  localparam logic [PIECE_BITS-1:0] BLACK_KNIGHT = 4'hA;
  localparam logic [PIECE_BITS-1:0] BLACK_BISHOP = 4'hB;
  localparam logic [PIECE_BITS-1:0] BLACK_ROOK   = 4'hC;
  localparam logic [PIECE_BITS-1:0] BLACK_QUEEN  = 4'hD;
  localparam logic [PIECE_BITS-1:0] BLACK_KING   = 4'hE;

  // IDLE: no evaluation running. EVAL: vchess is working on the active board.
  typedef enum logic {IDLE, EVAL} stager_state_t;

endpackage

// File: rtl/board_stager.sv
// Board stager: collects rank writes into a shadow board and launches complete
// boards to vchess, holding at most one further board queued behind a running
// evaluation.
//
// Handshakes: a rank write is taken on a cycle where rank_valid & rank_ready,
// a commit on a cycle where commit_valid & commit_ready. Both ready signals are
// low while a board is queued and while reset is asserted. The FSM state is
// fully visible on eval_busy (high exactly in EVAL).
module board_stager
  import vchess_pkg::*;
#(
  parameter int PIECE_WIDTH = PIECE_BITS,
  parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
  parameter int BOARD_WIDTH = PIECE_WIDTH * 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SIDE_WIDTH-1:0]  rank_data,
  input  logic [2:0]             rank_index,
  input  logic                   rank_valid,
  output logic                   rank_ready,
  input  logic                   commit_valid,
  input  logic                   commit_white_to_move,
  output logic                   commit_ready,
  input  logic                   is_attacking_done,
  output logic [BOARD_WIDTH-1:0] board,
  output logic                   board_valid,
  output logic                   white_to_move,
  output logic                   eval_busy,
  output logic [31:0]            eval_count,
  output logic                   commit_error,
  input  logic                   error_clear
);

  localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {64{PIECE_WIDTH'(EMPTY_POSN)}};

  stager_state_t          state, state_nxt;
  logic [BOARD_WIDTH-1:0] shadow;
  logic [7:0]             loaded;
  logic [BOARD_WIDTH-1:0] pend_board;
  logic                   pend_wtm;
  logic                   pending;

  logic                   rank_wr;
  logic                   commit_fire;
  logic [BOARD_WIDTH-1:0] eff_shadow;
  logic [7:0]             eff_loaded;
  logic                   commit_ok;
  logic                   commit_bad;
  logic                   done_eval;
  logic                   launch_direct;
  logic                   launch_pend;
  logic                   launch;
  logic                   queue_commit;
  logic [BOARD_WIDTH-1:0] launch_board;
  logic                   launch_wtm;

  // Accept writes and commits only when no board is queued.
  assign rank_ready   = ~reset & ~pending;
  assign commit_ready = ~reset & ~pending;
  assign rank_wr      = rank_valid & rank_ready;
  assign commit_fire  = commit_valid & commit_ready;

  // View of the shadow with a same-cycle rank write merged in, so a commit can
  // carry the rank that arrives alongside it.
  always_comb begin
    eff_shadow = shadow;
    eff_loaded = loaded;
    if (rank_wr) begin
      eff_shadow[rank_index*SIDE_WIDTH +: SIDE_WIDTH] = rank_data;
      eff_loaded[rank_index] = 1'b1;
    end
  end

  assign commit_ok  = commit_fire & (eff_loaded == 8'hFF);
  assign commit_bad = commit_fire & (eff_loaded != 8'hFF);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a completed evaluation returns to IDLE unless another
  // board launches in the same cycle (queued or directly committed).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (commit_ok) state_nxt = EVAL;
      EVAL: if (is_attacking_done && !pending && !commit_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and launch decode. A done is applied before a same-cycle
  // commit, so that commit launches straight away instead of queueing.
  always_comb begin
    eval_busy     = (state == EVAL);
    done_eval     = (state == EVAL) & is_attacking_done;
    launch_direct = commit_ok & ((state == IDLE) | done_eval);
    launch_pend   = done_eval & pending;
    launch        = launch_direct | launch_pend;
    queue_commit  = commit_ok & (state == EVAL) & ~done_eval;
    launch_board  = launch_pend ? pend_board : eff_shadow;
    launch_wtm    = launch_pend ? pend_wtm : commit_white_to_move;
  end

  // Shadow, queued and active boards plus counters and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow        <= '0;
      loaded        <= 8'h00;
      pend_board    <= '0;
      pend_wtm      <= 1'b1;
      pending       <= 1'b0;
      board         <= EMPTY_BOARD;
      board_valid   <= 1'b0;
      white_to_move <= 1'b1;
      eval_count    <= 32'd0;
      commit_error  <= 1'b0;
    end else begin
      if (rank_wr) shadow[rank_index*SIDE_WIDTH +: SIDE_WIDTH] <= rank_data;

      if (commit_ok)    loaded <= 8'h00;
      else if (rank_wr) loaded[rank_index] <= 1'b1;

      board_valid <= launch;
      if (launch) begin
        board         <= launch_board;
        white_to_move <= launch_wtm;
      end

      if (queue_commit) begin
        pend_board <= eff_shadow;
        pend_wtm   <= commit_white_to_move;
        pending    <= 1'b1;
      end else if (launch_pend) begin
        pending <= 1'b0;
      end

      if (done_eval) eval_count <= eval_count + 32'd1;

      if (commit_bad)       commit_error <= 1'b1;
      else if (error_clear) commit_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_board_stager.sv
// Bench for board_stager: directed rank/commit/done sequences; every launched
// board is checked against an expected queue by a separate monitor.
module tb_board_stager;
  import vchess_pkg::*;

  localparam int PW = PIECE_BITS;
  localparam int SW = PW * 8;
  localparam int BW = PW * 64;

  logic          clk;
  logic          reset;
  logic [SW-1:0] rank_data;
  logic [2:0]    rank_index;
  logic          rank_valid;
  logic          rank_ready;
  logic          commit_valid;
  logic          commit_white_to_move;
  logic          commit_ready;
  logic          is_attacking_done;
  logic [BW-1:0] board;
  logic          board_valid;
  logic          white_to_move;
  logic          eval_busy;
  logic [31:0]   eval_count;
  logic          commit_error;
  logic          error_clear;

  board_stager dut (
    .clk                  (clk),
    .reset                (reset),
    .rank_data            (rank_data),
    .rank_index           (rank_index),
    .rank_valid           (rank_valid),
    .rank_ready           (rank_ready),
    .commit_valid         (commit_valid),
    .commit_white_to_move (commit_white_to_move),
    .commit_ready         (commit_ready),
    .is_attacking_done    (is_attacking_done),
    .board                (board),
    .board_valid          (board_valid),
    .white_to_move        (white_to_move),
    .eval_busy            (eval_busy),
    .eval_count           (eval_count),
    .commit_error         (commit_error),
    .error_clear          (error_clear)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {white_to_move, board} per expected launch
  logic [BW:0] exp_q[$];
  logic [BW:0] mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  logic [BW-1:0] empty_bd;
  logic [BW-1:0] bd_start, bd_a, bd_b, bd_c, bd_d, bd_e, bd_f, bd_g;

  task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every board_valid pulse must match the oldest expected launch
  always @(negedge clk) begin
    if (!reset && board_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_board_valid: got board_valid=1 expected 0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("launch_wtm_board", {white_to_move, board}, mon_e);
      end
    end
  end

  function automatic logic [SW-1:0] start_rank(input int r);
    logic [PW-1:0] p[8];
    logic [SW-1:0] res;
    for (int f = 0; f < 8; f++) p[f] = EMPTY_POSN;
    case (r)
      0: begin
        p[0] = WHITE_ROOK; p[1] = WHITE_KNIGHT; p[2] = WHITE_BISHOP; p[3] = WHITE_QUEEN;
        p[4] = WHITE_KING; p[5] = WHITE_BISHOP; p[6] = WHITE_KNIGHT; p[7] = WHITE_ROOK;
      end
      1: for (int f = 0; f < 8; f++) p[f] = WHITE_PAWN;
      6: for (int f = 0; f < 8; f++) p[f] = BLACK_PAWN;
      7: begin
        p[0] = BLACK_ROOK; p[1] = BLACK_KNIGHT; p[2] = BLACK_BISHOP; p[3] = BLACK_QUEEN;
        p[4] = BLACK_KING; p[5] = BLACK_BISHOP; p[6] = BLACK_KNIGHT; p[7] = BLACK_ROOK;
      end
      default: ;
    endcase
    for (int f = 0; f < 8; f++) res[f*PW +: PW] = p[f];
    return res;
  endfunction

  function automatic logic [BW-1:0] pat_board(input int seed);
    logic [BW-1:0] b;
    for (int r = 0; r < 8; r++)
      for (int f = 0; f < 8; f++)
        b[(r*8+f)*PW +: PW] = PW'((seed * 5 + r * 7 + f * 3) % 16);
    return b;
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic write_rank(input int idx, input logic [SW-1:0] d);
    rank_valid = 1'b1;
    rank_index = 3'(idx);
    rank_data  = d;
    step(1);
    rank_valid = 1'b0;
  endtask

  task automatic load_board(input logic [BW-1:0] b, input int nranks);
    for (int r = 0; r < nranks; r++) write_rank(r, b[r*SW +: SW]);
  endtask

  task automatic commit(input logic wtm);
    commit_valid         = 1'b1;
    commit_white_to_move = wtm;
    step(1);
    commit_valid = 1'b0;
  endtask

  task automatic done_pulse();
    is_attacking_done = 1'b1;
    step(1);
    is_attacking_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rank_data = '0;
    rank_index = 3'd0;
    rank_valid = 1'b0;
    commit_valid = 1'b0;
    commit_white_to_move = 1'b0;
    is_attacking_done = 1'b0;
    error_clear = 1'b0;
    for (int s = 0; s < 64; s++) empty_bd[s*PW +: PW] = EMPTY_POSN;
    for (int r = 0; r < 8; r++) bd_start[r*SW +: SW] = start_rank(r);
    bd_a = pat_board(2);
    bd_b = pat_board(3);
    bd_c = pat_board(1);
    bd_d = pat_board(4);
    bd_e = pat_board(5);
    bd_f = pat_board(6);
    bd_g = pat_board(7);

    // reset values
    step(2);
    sample();
    chk("rst_rank_ready", rank_ready, 1'b0);
    chk("rst_commit_ready", commit_ready, 1'b0);
    chk("rst_board", board, empty_bd);
    chk("rst_board_valid", board_valid, 1'b0);
    chk("rst_wtm", white_to_move, 1'b1);
    chk("rst_eval_busy", eval_busy, 1'b0);
    chk("rst_eval_count", eval_count, 32'd0);
    chk("rst_commit_error", commit_error, 1'b0);
    step(1);
    reset = 1'b0;
    sample();
    chk("idle_commit_ready", commit_ready, 1'b1);

    // T1: start position, commit white to move
    load_board(bd_start, 8);
    exp_q.push_back({1'b1, bd_start});
    commit(1'b1);
    sample();
    chk("t1_valid_latency", board_valid, 1'b1);
    chk("t1_eval_busy", eval_busy, 1'b1);
    sample();
    chk("t1_valid_one_cycle", board_valid, 1'b0);
    done_pulse();
    exp_cnt++;
    sample();
    chk("t1_back_idle", eval_busy, 1'b0);
    chk("t1_eval_count", eval_count, 32'(exp_cnt));

    // T2: rank 7 missing
    load_board(bd_c, 7);
    commit(1'b0);
    sample();
    chk("t2_commit_error", commit_error, 1'b1);
    chk("t2_board_unchanged", {white_to_move, board}, {1'b1, bd_start});
    chk("t2_still_idle", eval_busy, 1'b0);
    error_clear = 1'b1;
    step(1);
    error_clear = 1'b0;
    sample();
    chk("t2_error_cleared", commit_error, 1'b0);

    // T3: queue B behind A
    load_board(bd_a, 8);
    exp_q.push_back({1'b1, bd_a});
    commit(1'b1);
    load_board(bd_b, 8);
    exp_q.push_back({1'b0, bd_b});
    commit(1'b0);
    sample();
    chk("t3_commit_ready_low", commit_ready, 1'b0);
    chk("t3_rank_ready_low", rank_ready, 1'b0);
    chk("t3_board_frozen", board, bd_a);
    done_pulse();
    exp_cnt++;
    sample();
    chk("t3_still_eval", eval_busy, 1'b1);
    chk("t3_count_first", eval_count, 32'(exp_cnt));
    chk("t3_commit_ready_back", commit_ready, 1'b1);
    done_pulse();
    exp_cnt++;
    sample();
    chk("t3_idle", eval_busy, 1'b0);
    chk("t3_count_second", eval_count, 32'(exp_cnt));

    // T4: rank 7 arrives with the commit
    load_board(bd_d, 7);
    exp_q.push_back({1'b1, bd_d});
    rank_valid = 1'b1;
    rank_index = 3'd7;
    rank_data = bd_d[7*SW +: SW];
    commit_valid = 1'b1;
    commit_white_to_move = 1'b1;
    step(1);
    rank_valid = 1'b0;
    commit_valid = 1'b0;
    sample();
    chk("t4_rank7_in_board", board[7*SW +: SW], bd_d[7*SW +: SW]);
    chk("t4_no_error", commit_error, 1'b0);

    // T4b: commit in the same cycle as done launches directly
    load_board(bd_e, 8);
    exp_q.push_back({1'b0, bd_e});
    commit_valid = 1'b1;
    commit_white_to_move = 1'b0;
    is_attacking_done = 1'b1;
    step(1);
    commit_valid = 1'b0;
    is_attacking_done = 1'b0;
    exp_cnt++;
    sample();
    chk("t4b_stay_eval", eval_busy, 1'b1);
    chk("t4b_count", eval_count, 32'(exp_cnt));
    chk("t4b_not_pending", commit_ready, 1'b1);
    done_pulse();
    exp_cnt++;
    sample();
    chk("t4b_idle", eval_busy, 1'b0);
    chk("t4b_count_after", eval_count, 32'(exp_cnt));

    // T5: reset while a board is queued
    load_board(bd_f, 8);
    exp_q.push_back({1'b1, bd_f});
    commit(1'b1);
    load_board(bd_g, 8);
    commit(1'b0);
    sample();
    chk("t5_pending_set", commit_ready, 1'b0);
    reset = 1'b1;
    #2;
    chk("t5_rst_board", board, empty_bd);
    chk("t5_rst_busy", eval_busy, 1'b0);
    chk("t5_rst_wtm", white_to_move, 1'b1);
    chk("t5_rst_count", eval_count, 32'd0);
    chk("t5_rst_rank_ready", rank_ready, 1'b0);
    step(1);
    reset = 1'b0;
    sample();
    chk("t5_pending_cleared", commit_ready, 1'b1);
    done_pulse();
    step(3);
    sample();
    chk("t5_done_ignored", eval_count, 32'd0);
    chk("t5_idle", eval_busy, 1'b0);
    commit(1'b1);
    sample();
    chk("t5_loaded_cleared", commit_error, 1'b1);

    chk("queue_drained", 257'(exp_q.size()), 257'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
